// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares the single-ported unified memory between the Fetch
// stage (instruction read) and the Memory stage (data read/write).
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   f_req/f_addr/f_flush          fetch request, PC, mispredict flush
//   f_done/f_rdata/f_err          fetch completion pulse, line, error
//   f_stall_req                   fetch waiting
//   m_req/m_we/m_addr/m_wdata     data request
//   m_done/m_rdata/m_err          data completion pulse, read data, error
//   m_stall_req                   data access waiting
//   mem_en/mem_we/mem_addr/mem_wdata  memory access (level handshake)
//   mem_rdata/mem_ready/mem_err   memory response
module pipe_mem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 80,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    input  logic               f_flush,
    output logic               f_done,
    output logic [INSTR_W-1:0] f_rdata,
    output logic               f_err,
    output logic               f_stall_req,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    output logic               m_done,
    output logic [DATA_W-1:0]  m_rdata,
    output logic               m_err,
    output logic               m_stall_req,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    input  logic               mem_err
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;
    typedef enum logic {OwnF, OwnM} owner_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                kill_q, kill_d;
    logic                f_done_q, f_done_d;
    logic                m_done_q, m_done_d;
    logic [INSTR_W-1:0]  f_rdata_q, f_rdata_d;
    logic                f_err_q, f_err_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                m_err_q, m_err_d;

    logic                f_elig;
    logic                grant_m;
    logic                finish;
    logic                kill_eff;
    logic [INSTR_W-1:0]  resp_rdata;
    logic                resp_err;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        kill_d       = kill_q;
        f_done_d     = 1'b0;
        m_done_d     = 1'b0;
        f_rdata_d    = f_rdata_q;
        f_err_d      = f_err_q;
        m_rdata_d    = m_rdata_q;
        m_err_d      = m_err_q;
        f_elig       = f_req & ~f_flush;
        // On contention the fetch wins only if data had the previous grant.
        grant_m      = m_req & ~(f_elig & (last_grant_q == OwnM));
        finish       = 1'b0;
        kill_eff     = kill_q | ((owner_q == OwnF) & f_flush);
        resp_rdata   = '0;
        resp_err     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                kill_d = 1'b0;
                if (grant_m) begin
                    owner_d      = OwnM;
                    last_grant_d = OwnM;
                    we_d         = m_we;
                    addr_d       = m_addr;
                    wdata_d      = m_wdata;
                    state_d      = StAcc;
                end else if (f_elig) begin
                    owner_d      = OwnF;
                    last_grant_d = OwnF;
                    we_d         = 1'b0;
                    addr_d       = f_addr;
                    wdata_d      = '0;
                    state_d      = StAcc;
                end
            end
            StAcc: begin
                kill_d = kill_eff;
                if (mem_ready) begin
                    resp_rdata = mem_rdata;
                    resp_err   = mem_err;
                    finish     = 1'b1;
                end else if (cnt_q == TimeoutLast) begin
                    resp_rdata = '0;
                    resp_err   = 1'b1;
                    finish     = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (finish) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    if (owner_q == OwnF) begin
                        // A flushed fetch completes silently.
                        if (!kill_eff) begin
                            f_done_d  = 1'b1;
                            f_rdata_d = resp_rdata;
                            f_err_d   = resp_err;
                        end
                    end else begin
                        m_done_d = 1'b1;
                        m_err_d  = resp_err;
                        if (!we_q) begin
                            m_rdata_d = resp_rdata[DATA_W-1:0];
                        end
                    end
                end
            end
            StResp: begin
                kill_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnF;
            last_grant_q <= OwnF;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            f_done_q     <= 1'b0;
            m_done_q     <= 1'b0;
            f_rdata_q    <= '0;
            f_err_q      <= 1'b0;
            m_rdata_q    <= '0;
            m_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            f_done_q     <= f_done_d;
            m_done_q     <= m_done_d;
            f_rdata_q    <= f_rdata_d;
            f_err_q      <= f_err_d;
            m_rdata_q    <= m_rdata_d;
            m_err_q      <= m_err_d;
        end
    end

    assign mem_en      = (state_q == StAcc);
    assign mem_we      = mem_en & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign f_done      = f_done_q;
    assign f_rdata     = f_rdata_q;
    assign f_err       = f_err_q;
    assign m_done      = m_done_q;
    assign m_rdata     = m_rdata_q;
    assign m_err       = m_err_q;
    assign f_stall_req = f_req & ~f_done_q;
    assign m_stall_req = m_req & ~m_done_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter.
module tb_pipe_mem_arbiter;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned INSTR_W = 80;
    localparam int unsigned TIMEOUT = 15;

    logic               clk;
    logic               rst_n;
    logic               f_req;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_flush;
    logic               f_done;
    logic [INSTR_W-1:0] f_rdata;
    logic               f_err;
    logic               f_stall_req;
    logic               m_req;
    logic               m_we;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic               m_done;
    logic [DATA_W-1:0]  m_rdata;
    logic               m_err;
    logic               m_stall_req;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ready;
    logic               mem_err;

    // Memory side: either forced by the bench or an auto-ready word model.
    logic               auto_mode;
    logic               ready_force;
    logic [INSTR_W-1:0] rdata_force;
    logic               err_force;
    logic [DATA_W-1:0]  model_mem [0:255];

    int n_checks;
    int n_fail;

    assign mem_ready = auto_mode ? mem_en : ready_force;
    assign mem_rdata = auto_mode ? {16'h0, model_mem[mem_addr[7:0]]} : rdata_force;
    assign mem_err   = err_force;

    always @(posedge clk) begin
        if (auto_mode && mem_en && mem_we && mem_ready) begin
            model_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    pipe_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INSTR_W(INSTR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_flush    (f_flush),
        .f_done     (f_done),
        .f_rdata    (f_rdata),
        .f_err      (f_err),
        .f_stall_req(f_stall_req),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .m_err      (m_err),
        .m_stall_req(m_stall_req),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++;
            $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_checks++; if (f_done !== 1'b0 || m_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_done: got f=%b m=%b want 0 0", f_done, m_done); end
        n_checks++; if (f_rdata !== '0 || m_rdata !== '0) begin n_fail++;
            $display("FAIL reset_rdata: got f=%h m=%h want 0", f_rdata, m_rdata); end
        n_checks++; if (f_err !== 1'b0 || m_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_err: got f=%b m=%b want 0 0", f_err, m_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h100; ready_force = 1'b1;
        rdata_force = 80'h30F2_0A00_0000_0000_0000;
        #1;
        n_checks++; if (f_stall_req !== 1'b1) begin n_fail++;
            $display("FAIL fetch_stall_idle: got %b want 1", f_stall_req); end
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_acc: got en=%b addr=%h we=%b want 1 100 0",
                     mem_en, mem_addr, mem_we); end
        n_checks++; if (f_done !== 1'b0) begin n_fail++;
            $display("FAIL fetch_done_early: got %b want 0", f_done); end
        @(negedge clk);
        n_checks++; if (f_done !== 1'b1 || f_rdata !== 80'h30F2_0A00_0000_0000_0000) begin
            n_fail++;
            $display("FAIL fetch_done: got done=%b rdata=%h want 1 30f20a00000000000000",
                     f_done, f_rdata); end
        n_checks++; if (f_err !== 1'b0 || mem_en !== 1'b0 || f_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: got err=%b en=%b stall=%b want 0 0 0",
                     f_err, mem_en, f_stall_req); end
        f_req = 1'b0; ready_force = 1'b0;
        @(negedge clk);
        n_checks++; if (f_done !== 1'b0) begin n_fail++;
            $display("FAIL fetch_done_pulse: got %b want 0", f_done); end
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] exp_addr;
        @(negedge clk);
        rst_n = 1'b0;
        f_req = 1'b1; f_addr = 64'h40;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h200;
        ready_force = 1'b1; rdata_force = 80'h1111_2222_3333_4444_5555;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 64'h200 : 64'h40;
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin n_fail++;
                $display("FAIL contend_acc%0d: got en=%b addr=%h want 1 %h",
                         i, mem_en, mem_addr, exp_addr); end
            n_checks++; if (m_stall_req !== 1'b1) begin n_fail++;
                $display("FAIL contend_mstall_acc%0d: got %b want 1", i, m_stall_req); end
            @(negedge clk);
            if (i % 2 == 0) begin
                n_checks++; if (m_done !== 1'b1 || f_done !== 1'b0 || m_stall_req !== 1'b0)
                begin n_fail++;
                    $display("FAIL contend_mdone%0d: got m=%b f=%b stall=%b want 1 0 0",
                             i, m_done, f_done, m_stall_req); end
                n_checks++; if (m_rdata !== 64'h2222_3333_4444_5555) begin n_fail++;
                    $display("FAIL contend_mrdata%0d: got %h want 2222333344445555",
                             i, m_rdata); end
            end else begin
                n_checks++; if (f_done !== 1'b1 || m_done !== 1'b0 || m_stall_req !== 1'b1)
                begin n_fail++;
                    $display("FAIL contend_fdone%0d: got f=%b m=%b stall=%b want 1 0 1",
                             i, f_done, m_done, m_stall_req); end
            end
            if (i == 3) begin
                f_req = 1'b0; m_req = 1'b0;
            end
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b0) begin n_fail++;
                $display("FAIL contend_idle%0d: got en=%b want 0", i, mem_en); end
        end
        ready_force = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        auto_mode = 1'b1;
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h80; m_wdata = 64'hDEAD;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h80 ||
                        mem_wdata !== 64'hDEAD) begin n_fail++;
            $display("FAIL wr_acc: got en=%b we=%b addr=%h wdata=%h want 1 1 80 dead",
                     mem_en, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        n_checks++; if (m_done !== 1'b1 || m_rdata !== 64'h2222_3333_4444_5555) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b rdata=%h want 1 2222333344445555",
                     m_done, m_rdata); end
        m_we = 1'b0;
        @(negedge clk);
        n_checks++; if (m_done !== 1'b0) begin n_fail++;
            $display("FAIL wr_done_pulse: got %b want 0", m_done); end
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++;
            $display("FAIL rd_acc: got en=%b we=%b want 1 0", mem_en, mem_we); end
        @(negedge clk);
        n_checks++; if (m_done !== 1'b1 || m_rdata !== 64'hDEAD || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done: got done=%b rdata=%h err=%b want 1 dead 0",
                     m_done, m_rdata, m_err); end
        m_req = 1'b0;
        auto_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int en_cnt;
        bit seen;
        en_cnt = 0;
        seen   = 1'b0;
        @(negedge clk);
        ready_force = 1'b0;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h300;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (m_done) begin
                seen = 1'b1;
                m_req = 1'b0;
                n_checks++; if (m_err !== 1'b1 || m_rdata !== '0) begin n_fail++;
                    $display("FAIL timeout_resp: got err=%b rdata=%h want 1 0",
                             m_err, m_rdata); end
            end
        end
        m_req = 1'b0;
        n_checks++; if (!seen) begin n_fail++;
            $display("FAIL timeout_done: got no m_done in 40 cycles want m_done"); end
        n_checks++; if (en_cnt != TIMEOUT) begin n_fail++;
            $display("FAIL timeout_len: got mem_en cycles=%0d want %0d", en_cnt, TIMEOUT); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h70; ready_force = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1) begin n_fail++;
            $display("FAIL flush_acc1: got en=%b want 1", mem_en); end
        f_flush = 1'b1;
        @(negedge clk);
        f_flush = 1'b0;
        @(negedge clk);
        ready_force = 1'b1; rdata_force = 80'hBAD0_BAD0_BAD0_BAD0_BAD0; f_req = 1'b0;
        n_checks++; if (mem_en !== 1'b1 || f_done !== 1'b0) begin n_fail++;
            $display("FAIL flush_acc3: got en=%b done=%b want 1 0", mem_en, f_done); end
        @(negedge clk);
        n_checks++; if (f_done !== 1'b0 || f_rdata !== 80'h1111_2222_3333_4444_5555) begin
            n_fail++;
            $display("FAIL flush_killed: got done=%b rdata=%h want 0 11112222333344445555",
                     f_done, f_rdata); end
        ready_force = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || f_done !== 1'b0) begin n_fail++;
            $display("FAIL flush_idle: got en=%b done=%b want 0 0", mem_en, f_done); end
        f_req = 1'b1; f_addr = 64'h58; f_flush = 1'b1;
        ready_force = 1'b1; rdata_force = 80'h6000_0000_0000_0000_0058;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++;
            $display("FAIL flush_idle_block: got en=%b want 0", mem_en); end
        f_flush = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h58) begin n_fail++;
            $display("FAIL refetch_acc: got en=%b addr=%h want 1 58", mem_en, mem_addr); end
        @(negedge clk);
        n_checks++; if (f_done !== 1'b1 || f_rdata !== 80'h6000_0000_0000_0000_0058) begin
            n_fail++;
            $display("FAIL refetch_done: got done=%b rdata=%h want 1 60000000000000000058",
                     f_done, f_rdata); end
        f_req = 1'b0; ready_force = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h400; ready_force = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1) begin n_fail++;
            $display("FAIL areset_acc2: got en=%b want 1", mem_en); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_en !== 1'b0 || m_done !== 1'b0 || f_done !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: got en=%b m=%b f=%b want 0 0 0",
                     mem_en, m_done, f_done); end
        m_req = 1'b0;
        @(negedge clk);
        n_checks++; if (f_rdata !== '0 || m_done !== 1'b0) begin n_fail++;
            $display("FAIL areset_hold: got rdata=%h mdone=%b want 0 0", f_rdata, m_done); end
        rst_n = 1'b1;
        m_req = 1'b1; m_addr = 64'h408; ready_force = 1'b1;
        rdata_force = 80'h0000_0000_0000_CAFE_F00D;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h408) begin n_fail++;
            $display("FAIL areset_new_acc: got en=%b addr=%h want 1 408", mem_en, mem_addr); end
        @(negedge clk);
        n_checks++; if (m_done !== 1'b1 || m_rdata !== 64'hCAFE_F00D) begin n_fail++;
            $display("FAIL areset_new_done: got done=%b rdata=%h want 1 cafef00d",
                     m_done, m_rdata); end
        m_req = 1'b0; ready_force = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        auto_mode = 1'b0; ready_force = 1'b0; rdata_force = '0; err_force = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_write_read();
        test_timeout();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares the single-ported unified memory between the Fetch stage (instruction read) and the Memory stage (data read/write) of the Y86-64 pipeline.
- Sequences each access with a level handshake to the memory and enforces a timeout.
- Produces per-requester stall requests that the pipeline hazard controller ORs into F_stall and the M-stage stall.
- Supports flushing an in-flight fetch on a mispredicted branch.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data-stage word width.
- INSTR_W, 80, fetch line width (max Y86 instruction, 10 bytes).
- TIMEOUT, 15, max cycles in ACC before forced error completion (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request, held until f_done.
- f_addr  in  ADDR_W  fetch PC.
- f_flush  in  1  discard current or pending fetch (mispredict).
- f_done  out  1  one-cycle fetch completion pulse.
- f_rdata  out  INSTR_W  fetched bytes, valid with f_done.
- f_err  out  1  fetch error, valid with f_done.
- f_stall_req  out  1  fetch waiting.
- m_req  in  1  data request, held until m_done.
- m_we  in  1  1 = write.
- m_addr  in  ADDR_W  data address.
- m_wdata  in  DATA_W  write data.
- m_done  out  1  one-cycle data completion pulse.
- m_rdata  out  DATA_W  read data, valid with m_done.
- m_err  out  1  data error, valid with m_done (maps to SADR).
- m_stall_req  out  1  data access waiting.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  INSTR_W  memory read data; data reads use bits [DATA_W-1:0].
- mem_ready  in  1  access complete.
- mem_err  in  1  access error, qualified by mem_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE; last_grant=F; all outputs 0, including f_done, m_done, mem_en, rdata and err registers; timeout counter 0.
- Reset asserted mid-access: the access is abandoned and mem_en drops immediately. No done pulse is ever produced for it.
- State IDLE:
  - If m_req and f_req (with !f_flush) are both asserted, grant F only when last_grant==M; otherwise grant M.
  - If only one is asserted, grant it. A fetch is not eligible while f_flush is high.
  - At grant, latch owner, we, addr and wdata into registers. A fetch grant forces we=0. Set last_grant=owner and go to ACC.
- State ACC:
  - mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latched registers and held stable.
  - mem_ready is sampled every ACC cycle, including the first.
  - On mem_ready: capture mem_rdata and mem_err, go to RESP.
  - Timeout: the counter increments each ACC cycle without mem_ready. When it reaches TIMEOUT-1 with no ready, go to RESP with err=1 and rdata=0.
  - mem_en is 0 in every state other than ACC.
- State RESP:
  - Pulse the owner's done for one cycle, with rdata and err, then go to IDLE.
  - Minimum latency from req (seen in IDLE) to done is 3 cycles when mem_ready arrives in the first ACC cycle.
  - Inputs are ignored in RESP.
  - Requesters must deassert or change req in the cycle after done.
- Flush:
  - f_flush while owner=F in ACC sets a kill flag. The memory access runs to completion.
  - In RESP, a killed fetch produces no f_done, and f_rdata/f_err are not updated.
  - f_flush coincident with f_done in RESP has no effect on that completed fetch.
  - f_flush in IDLE blocks a fetch grant for that cycle only.
- Stall requests (combinational):
  - f_stall_req = f_req & ~f_done.
  - m_stall_req = m_req & ~m_done.
- Writes: m_done pulses and m_rdata holds its previous value.
- Widths: all address and data paths are pass-through with no arithmetic. The timeout counter is 8 bits and saturates; it never wraps.

Test Plan:
- Single fetch: f_req, f_addr=0x100, mem_ready in the 1st ACC cycle with mem_rdata=0x30F2_0A00...: f_done at cycle 3 with matching f_rdata, f_err=0, mem_en high exactly 1 cycle.
- Contention fairness: f_req and m_req held from reset release:
  - Grant order is M, F, M, F.
  - mem_addr alternates between m_addr=0x200 and f_addr=0x40.
  - m_stall_req stays high until each m_done.
- Write then read: m_we=1, m_addr=0x80, m_wdata=0xDEAD; then a read of 0x80 against a memory model returning the stored word. m_done fires twice; the second has m_rdata=0xDEAD and mem_we=0.
- Timeout: m_req with mem_ready held 0: mem_en high for exactly TIMEOUT cycles, then m_done with m_err=1 and m_rdata=0.
- Flush in flight: fetch granted, f_flush pulsed in ACC cycle 1, mem_ready in cycle 3: no f_done, state returns to IDLE, and a following fetch of 0x58 completes normally.
- Async reset mid-ACC: rst_n low in ACC cycle 2. mem_en, f_done and m_done go to 0 without waiting for a clock edge. After release, a new m_req completes in 3 cycles.
